// File: rtl/tt_um_prng_top.sv
// rtl/tt_um_prng_top.sv - 16-bit Galois LFSR random number generator, Tiny Tapeout top
//
// The LFSR advances every cycle (FREE), on a rate-programmable tick, or once
// per rising edge of the synchronized STEP input. State is shown as raw
// bytes or, when built with SEVENSEG_EN, as a 7-segment hex digit with a
// tick-toggled decimal point. A seed byte is loaded through the bidir port.
//
// Build option: SEVENSEG_EN - when defined, ui_in[3] (DISP) selects the
// 7-segment view on uo_out; when undefined, uo_out always shows s[7:0].
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst_n    synchronous reset, active HIGH (historical name kept)
//   ena      Tiny Tapeout enable, ignored
//   ui_in    [0] FREE [1] STEP [2] HOLD [3] DISP [4] LOAD [7:5] RATE
//   uo_out   s[7:0] or {dp, g, f, e, d, c, b, a}
//   uio_in   seed byte for LOAD
//   uio_out  s[15:8]
//   uio_oe   0xFF, or 0x00 while LOAD is high so the seed can be driven in

module tt_um_prng_top #(
    parameter int unsigned CLK_FREQ = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [15:0] SEED_VAL = 16'hACE1;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [31:0] FREQ_W   = CLK_FREQ;

    logic        free_in;
    logic        step_in;
    logic        hold_in;
    logic        load_in;
    logic [2:0]  rate_in;

    logic [15:0] s_q, s_d;
    logic [31:0] cnt_q, cnt_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;

    logic [31:0] period;
    logic [31:0] limit;
    logic        tick;
    logic        step_edge;
    logic [15:0] lfsr_next;

    assign free_in = ui_in[0];
    assign step_in = ui_in[1];
    assign hold_in = ui_in[2];
    assign load_in = ui_in[4];
    assign rate_in = ui_in[7:5];

    // Tick generator and step edge detect
    always_comb begin
        period = FREQ_W >> rate_in;
        limit  = period - 32'd1;
        // A zero period would make limit wrap to all-ones; treat it as
        // "tick every cycle" instead. LOAD freezes the counter, so no tick.
        tick   = !load_in && ((period == 32'd0) || (cnt_q >= limit));
        if (load_in || tick) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        sync1_d   = step_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        step_edge = sync2_q & ~prev_q;
    end

    // LFSR next-state with LOAD > HOLD > FREE > tick/step priority
    always_comb begin
        lfsr_next = {1'b0, s_q[15:1]} ^ (s_q[0] ? TAPS : 16'h0000);
        s_d       = s_q;
        if (load_in) begin
            // Low byte is XORed with 0x5A so a zero seed byte never gives s=0.
            s_d = {uio_in, uio_in ^ 8'h5A};
        end else if (hold_in) begin
            s_d = s_q;
        end else if (free_in) begin
            s_d = lfsr_next;
        end else if (tick || step_edge) begin
            s_d = lfsr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s_q     <= SEED_VAL;
            cnt_q   <= 32'd0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign uio_out = s_q[15:8];
    assign uio_oe  = load_in ? 8'h00 : 8'hFF;

`ifdef SEVENSEG_EN
    logic       dp_q, dp_d;
    logic [6:0] seg;
    logic       unused_ok;

    assign unused_ok = &{1'b0, ena};

    always_comb begin
        dp_d = dp_q ^ tick;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dp_q <= 1'b0;
        end else begin
            dp_q <= dp_d;
        end
    end

    // Active-high segments {g,f,e,d,c,b,a}
    always_comb begin
        seg = 7'h00;
        case (s_q[3:0])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    always_comb begin
        uo_out = ui_in[3] ? {dp_q, seg} : s_q[7:0];
    end
`else
    logic unused_ok;

    assign unused_ok = &{1'b0, ena, ui_in[3]};

    always_comb begin
        uo_out = s_q[7:0];
    end
`endif

endmodule

// File: tb/tb_tt_um_prng_top.sv
// tb/tb_tt_um_prng_top.sv - scoreboard bench for tt_um_prng_top

module tb_tt_um_prng_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_a, uio_out_a, uio_oe_a;
    logic [7:0] uo_b, uio_out_b, uio_oe_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          inst;
        logic [23:0] exp;
    } exp_t;

    exp_t sb[$];

    // Instance A: default 10 MHz base; instance B: 16 Hz base for tick tests.
    tt_um_prng_top dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_a),
        .uio_in(uio_in), .uio_out(uio_out_a), .uio_oe(uio_oe_a)
    );

    tt_um_prng_top #(.CLK_FREQ(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_b),
        .uio_in(uio_in), .uio_out(uio_out_b), .uio_oe(uio_oe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEVENSEG_EN
    localparam logic [7:0] DISP_RESET = 8'h06;
    localparam logic [7:0] DISP_TICK  = 8'hBF;
`else
    localparam logic [7:0] DISP_RESET = 8'hE1;
    localparam logic [7:0] DISP_TICK  = 8'h70;
`endif

    // Monitor: compares every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [23:0] act;
            e   = sb.pop_front();
            act = e.inst ? {uio_oe_b, uio_out_b, uo_b} : {uio_oe_a, uio_out_a, uo_a};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got {oe,uio,uo}=%h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_out(input string name, input bit inst, input logic [23:0] exp);
        exp_t e;
        e.name = name;
        e.inst = inst;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] ui);
        tick_clk(1);
        rst_n = 1'b1;
        ui_in = ui;
        tick_clk(1);
        rst_n = 1'b0;
    endtask

    logic [15:0] step_exp [5];

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        step_exp = '{16'hACE1, 16'hACE1, 16'hE270, 16'hE270, 16'hE270};

        // Reset state, then 100 idle cycles with no tick at 10 MHz base
        tick_clk(2);
        rst_n = 1'b0;
        expect_out("reset_a", 1'b0, 24'hFFACE1);
        expect_out("reset_b", 1'b1, 24'hFFACE1);
        tick_clk(100);
        expect_out("idle_100", 1'b0, 24'hFFACE1);

        // FREE run
        do_reset(8'h01);
        tick_clk(1); expect_out("free_1", 1'b0, 24'hFFE270);
        tick_clk(1); expect_out("free_2", 1'b0, 24'hFF7138);
        tick_clk(1); expect_out("free_3", 1'b0, 24'hFF389C);

        // LOAD seed 0x12, then release into FREE
        do_reset(8'h00);
        ui_in  = 8'h10;
        uio_in = 8'h12;
        expect_out("load_oe", 1'b0, 24'h00ACE1);
        tick_clk(1); expect_out("load_state", 1'b0, 24'h001248);
        tick_clk(1);
        ui_in = 8'h01;
        expect_out("load_release", 1'b0, 24'hFF1248);
        tick_clk(1); expect_out("load_free", 1'b0, 24'hFF0924);

        // STEP held high five cycles: one advance on the third edge
        do_reset(8'h00);
        ui_in = 8'h02;
        for (int i = 0; i < 5; i++) begin
            tick_clk(1);
            expect_out($sformatf("step_%0d", i + 1), 1'b0, {8'hFF, step_exp[i]});
        end
        tick_clk(1);
        ui_in = 8'h04;
        tick_clk(3);
        ui_in = 8'h06;
        for (int i = 0; i < 5; i++) begin
            tick_clk(1);
            expect_out($sformatf("hold_step_%0d", i + 1), 1'b0, 24'hFFE270);
        end

        // Tick at RATE=0 on 16 Hz base with DISP: every 16 cycles, dp toggles
        do_reset(8'h08);
        tick_clk(15);
        expect_out("rate0_pre", 1'b1, {16'hFFAC, DISP_RESET});
        expect_out("disp_notick", 1'b0, {16'hFFAC, DISP_RESET});
        tick_clk(1);
        expect_out("rate0_tick", 1'b1, {16'hFFE2, DISP_TICK});

        // RATE=2: every 4 cycles
        do_reset(8'h40);
        tick_clk(3); expect_out("rate2_pre", 1'b1, 24'hFFACE1);
        tick_clk(1); expect_out("rate2_t1", 1'b1, 24'hFFE270);
        tick_clk(4); expect_out("rate2_t2", 1'b1, 24'hFF7138);

        // RATE=7: period shifts to zero, tick every cycle
        do_reset(8'hE0);
        tick_clk(1); expect_out("rate7_1", 1'b1, 24'hFFE270);
        tick_clk(1); expect_out("rate7_2", 1'b1, 24'hFF7138);
        tick_clk(1); expect_out("rate7_3", 1'b1, 24'hFF389C);

        // Reset overrides LOAD/FREE on the same edge
        do_reset(8'h01);
        tick_clk(3);
        rst_n  = 1'b1;
        ui_in  = 8'h15;
        uio_in = 8'h12;
        tick_clk(1);
        expect_out("reset_override", 1'b0, 24'h00ACE1);
        rst_n = 1'b0;
        tick_clk(1);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_prng_top.md
Name: tt_um_prng_top

Overview:
- Tiny Tapeout top-level pseudo-random number generator built around a 16-bit Galois LFSR.
- The LFSR advances free-running, on a programmable-rate tick derived from CLK_FREQ, or on a debounced-by-sync step input.
- Outputs the state as raw bytes or as a 7-segment hex digit. Seed is loadable through the bidirectional port.

Parameters:
- CLK_FREQ, 10_000_000, input clock frequency in Hz; the tick period base is CLK_FREQ cycles (1 Hz at rate 0).

Ports:
- clk  input  1  system clock; one clock, all state on its rising edge.
- rst_n  input  1  reset; keeps the codebase port name. Reset is synchronous and active-high: rst_n=1 resets on the clock edge.
- ena  input  1  Tiny Tapeout enable; ignored, the design runs regardless.
- ui_in  input  8  [0] FREE, [1] STEP, [2] HOLD, [3] DISP, [4] LOAD, [7:5] RATE.
- uo_out  output  8  raw LFSR[7:0], or 7-segment {dp,g,f,e,d,c,b,a}.
- uio_in  input  8  seed byte, used when LOAD=1.
- uio_out  output  8  LFSR[15:8], always driven.
- uio_oe  output  8  0xFF normally; 0x00 while LOAD=1.

Behaviour:
- LFSR step (Galois, right shift): b=s[0]; s=s>>1; if b then s^=0xB400. Never reaches zero from a nonzero state.
- Reset value: s=0xACE1. Also cleared on reset: tick counter=0, dp=0, step synchronizer flops=0.
- Reset output values: uo_out=0xE1 (raw) and uio_out=0xAC.
- State update priority, evaluated each rising edge:
  - 1. reset.
  - 2. LOAD=1: s={uio_in, uio_in^0x5A}, which is never zero; tick counter cleared.
  - 3. HOLD=1: s unchanged.
  - 4. FREE=1: advance every cycle.
  - 5. otherwise advance once if tick or step_edge; both in the same cycle give a single advance.
- Tick generator:
  - limit=(CLK_FREQ>>RATE)-1, computed with 32-bit unsigned arithmetic.
  - Counter increments each cycle; when counter>=limit: tick=1 for one cycle and counter wraps to 0.
  - If CLK_FREQ>>RATE is 0, tick every cycle.
  - A RATE change mid-count takes effect immediately (>= comparison).
  - The counter runs during HOLD and FREE. It is frozen and cleared only by reset or LOAD.
- dp toggles on every tick, independent of HOLD.
- STEP path: two-flop synchronizer, then a previous-value flop; step_edge = sync2 & ~prev.
  - The LFSR advances on the 3rd rising edge at which STEP is sampled high.
  - A held-high STEP yields exactly one advance.
- Outputs are registered-state derived, combinational from s and dp (no extra latency).
- DISP=0: uo_out=s[7:0].
- DISP=1: uo_out={dp, seg(s[3:0])}, active-high segments.
  - 0-7: 3F 06 5B 4F 66 6D 7D 07.
  - 8-F: 7F 6F 77 7C 39 5E 79 71.
- uio_out=s[15:8] in all modes.
- Reset asserted mid-operation overrides LOAD/HOLD/FREE on that edge.

Optional Feature:
- Macro SEVENSEG_EN.
- Defined: DISP selects the 7-segment encoding as above.
- Undefined: decoder and dp toggle logic omitted; DISP ignored, uo_out=s[7:0] always.
- Everything else is identical in both builds.

Test Plan:
- Reset (rst_n=1 one edge, ui_in=0x00) -> uo_out=0xE1, uio_out=0xAC, uio_oe=0xFF; state stays fixed for 100 cycles (no tick at CLK_FREQ=10e6).
- FREE=1 (ui_in=0x01) after reset -> {uio_out,uo_out} per cycle: 0xE270, 0x7138, 0x389C.
- LOAD=1, uio_in=0x12 -> uio_oe=0x00. After the edge, state=0x1248; after releasing LOAD with FREE=1, next state=0x0924.
- STEP rising from 0 held 5 cycles (FREE=0, HOLD=0) -> exactly one advance, 0xACE1->0xE270, on the 3rd edge; HOLD=1 with a STEP pulse -> no change.
- CLK_FREQ=16, RATE=0 -> tick every 16 cycles (state advances, dp toggles). RATE=2 -> every 4 cycles. RATE=7 -> every cycle.
- DISP=1 (SEVENSEG_EN defined) after reset -> uo_out=0x06. After one tick: s=0xE270, uo_out=0xBF ({dp=1, seg(0)=0x3F}).
